// File: rtl/kyber_pkg.sv
// Shared Kyber constants: polynomial geometry, i_l-to-d width mapping and the
// encode/decode FSM state encoding.
package kyber_pkg;

  localparam int N               = 256;
  localparam int COEFF_W         = 12;
  localparam int COEFFS_PER_BEAT = 4;
  localparam int BEATS           = N / COEFFS_PER_BEAT;
  localparam int BEAT_W          = COEFF_W * COEFFS_PER_BEAT;
  localparam int WORD_W          = 64;
  localparam int BUF_W           = 112;
  localparam int CNT_W           = 7;

  typedef enum logic [1:0] {
    L_D12 = 2'b00,
    L_D11 = 2'b01,
    L_D10 = 2'b10,
    L_D4  = 2'b11
  } l_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] l_to_d(input logic [1:0] l);
    case (l)
      L_D12:   return 4'd12;
      L_D11:   return 4'd11;
      L_D10:   return 4'd10;
      default: return 4'd4;
    endcase
  endfunction

  // Number of stream bits one input beat contributes (4 coefficients x d).
  function automatic logic [CNT_W-1:0] beat_bits(input logic [1:0] l);
    return {1'b0, l_to_d(l), 2'b00};
  endfunction

endpackage

// File: rtl/encode_compact.sv
// Squeezes four 12-bit coefficients into one contiguous 4d-bit field, dropping
// each coefficient's bits above d. Upper field bits are always zero.
module encode_compact
  import kyber_pkg::*;
(
  input  logic [BEAT_W-1:0] i_coeffs,
  input  logic [1:0]        i_l,
  output logic [BEAT_W-1:0] o_field
);

  logic [COEFF_W-1:0] w_c0, w_c1, w_c2, w_c3;

  assign w_c0 = i_coeffs[11:0];
  assign w_c1 = i_coeffs[23:12];
  assign w_c2 = i_coeffs[35:24];
  assign w_c3 = i_coeffs[47:36];

  always_comb begin
    o_field = '0;
    case (i_l)
      L_D12:   o_field = {w_c3, w_c2, w_c1, w_c0};
      L_D11:   o_field = {4'd0, w_c3[10:0], w_c2[10:0], w_c1[10:0], w_c0[10:0]};
      L_D10:   o_field = {8'd0, w_c3[9:0], w_c2[9:0], w_c1[9:0], w_c0[9:0]};
      default: o_field = {32'd0, w_c3[3:0], w_c2[3:0], w_c1[3:0], w_c0[3:0]};
    endcase
  end

endmodule

// File: rtl/encode.sv
// ByteEncode_d: packs one 256-coefficient polynomial (64 beats of 4 coeffs)
// into an LSB-first stream of 64-bit words through a 112-bit bit buffer.
module encode
  import kyber_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BEAT_W-1:0]   i_coeffs,
  input  logic                i_coeffs_valid,
  output logic                o_coeffs_ready,
  input  logic [1:0]          i_l,
  output logic [WORD_W-1:0]   o_obytes,
  output logic                o_obytes_valid,
  input  logic                i_obytes_ready,
  output logic                o_done
);

  // Handshakes: a beat moves when i_coeffs_valid && o_coeffs_ready, a word
  // when o_obytes_valid && i_obytes_ready; a stalled word never changes.
  state_e             r_state;
  state_e             w_state_nxt;
  logic [1:0]         r_l;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_beats;
  logic [BUF_W-1:0]   r_buf;
  logic               r_valid;

  logic [1:0]         w_l_eff;
  logic [BEAT_W-1:0]  w_field;
  logic               w_ready;
  logic               w_in_fire;
  logic               w_out_fire;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BUF_W-1:0]   w_buf_nxt;

  // The width is taken live from i_l only for the beat that opens a polynomial.
  assign w_l_eff = (r_state == ST_IDLE) ? i_l : r_l;

  encode_compact u_compact (
    .i_coeffs (i_coeffs),
    .i_l      (w_l_eff),
    .o_field  (w_field)
  );

  // Ready depends only on registered state so downstream stalls never ripple back.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_PACK: w_ready = (r_beats < CNT_W'(BEATS)) && !r_cnt[6];
      default: w_ready = 1'b0;
    endcase
  end

  assign o_coeffs_ready = w_ready & ~i_rst;
  assign w_in_fire      = i_coeffs_valid & o_coeffs_ready;
  assign w_out_fire     = r_valid & i_obytes_ready;

  // Drain first, then append at the post-drain fill level; bits above cnt stay zero.
  always_comb begin
    w_buf_nxt = r_buf;
    w_cnt_nxt = r_cnt;
    if (w_out_fire) begin
      w_buf_nxt = {{WORD_W{1'b0}}, r_buf[BUF_W-1:WORD_W]};
      w_cnt_nxt = r_cnt - CNT_W'(WORD_W);
    end
    if (w_in_fire) begin
      w_buf_nxt = w_buf_nxt | (BUF_W'(w_field) << w_cnt_nxt);
      w_cnt_nxt = w_cnt_nxt + beat_bits(w_l_eff);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_in_fire) w_state_nxt = ST_PACK;
      ST_PACK: begin
        if (w_out_fire && (r_beats == CNT_W'(BEATS)) && (w_cnt_nxt == '0))
          w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_l     <= L_D12;
      r_cnt   <= '0;
      r_beats <= '0;
      r_buf   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_buf   <= w_buf_nxt;
      r_valid <= w_cnt_nxt[6];
      if (r_state == ST_IDLE && w_in_fire) begin
        r_l     <= i_l;
        r_beats <= CNT_W'(1);
      end else if (r_state == ST_DONE) begin
        r_beats <= '0;
      end else if (w_in_fire) begin
        r_beats <= r_beats + CNT_W'(1);
      end
    end
  end

  assign o_obytes       = r_buf[WORD_W-1:0];
  assign o_obytes_valid = r_valid;
  assign o_done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_encode.sv
// Scoreboard bench for encode: a bit-level reference model fills exp_q when a
// polynomial is driven; the monitor pops and compares each accepted word.
module tb_encode;

  logic        i_clk          = 1'b0;
  logic        i_rst          = 1'b1;
  logic [47:0] i_coeffs       = '0;
  logic        i_coeffs_valid = 1'b0;
  logic [1:0]  i_l            = 2'b00;
  logic        i_obytes_ready = 1'b0;
  logic        o_coeffs_ready;
  logic [63:0] o_obytes;
  logic        o_obytes_valid;
  logic        o_done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [11:0] coef[256];

  bit          bp_random     = 1'b0;
  int          cyc           = 0;
  int          done_cnt      = 0;
  int          done_cyc      = 0;
  int          words_seen    = 0;
  int          first_acc_cyc = 0;
  logic [63:0] first_word    = '0;
  bit          stall_prev    = 1'b0;
  logic [63:0] stall_word    = '0;

  encode dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_coeffs       (i_coeffs),
    .i_coeffs_valid (i_coeffs_valid),
    .o_coeffs_ready (o_coeffs_ready),
    .i_l            (i_l),
    .o_obytes       (o_obytes),
    .o_obytes_valid (o_obytes_valid),
    .i_obytes_ready (i_obytes_ready),
    .o_done         (o_done)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc = cyc + 1;

  always @(posedge i_clk) begin
    #1;
    i_obytes_ready = bp_random ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge i_clk) begin
    if (i_rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", 64'(o_obytes_valid), 64'd1);
        check_eq("stall_word", o_obytes, stall_word);
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_obytes_valid && i_obytes_ready) begin
        if (words_seen == 0) first_word = o_obytes;
        words_seen++;
        check_eq("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_eq("word", o_obytes, exp_q.pop_front());
      end
      stall_prev = o_obytes_valid && !i_obytes_ready;
      stall_word = o_obytes;
    end
  end

  // ---------------- reference model ----------------
  task automatic push_model(input logic [1:0] l);
    int          d;
    int          n;
    logic [63:0] w;
    d = (l == 2'b00) ? 12 : (l == 2'b01) ? 11 : (l == 2'b10) ? 10 : 4;
    n = 0;
    w = '0;
    for (int j = 0; j < 256; j++) begin
      for (int b = 0; b < d; b++) begin
        w[n % 64] = coef[j][b];
        n++;
        if (n % 64 == 0) begin
          exp_q.push_back(w);
          w = '0;
        end
      end
    end
  endtask

  task automatic fill_random();
    for (int j = 0; j < 256; j++) coef[j] = 12'($urandom_range(0, 4095));
  endtask

  // ---------------- drivers ----------------
  task automatic send_poly(input logic [1:0] l, input int nbeats, input bit toggle_l,
                           input bit keep_valid);
    for (int i = 0; i < nbeats; i++) begin
      bit acc;
      int guard;
      i_coeffs       = {coef[4*i+3], coef[4*i+2], coef[4*i+1], coef[4*i]};
      i_coeffs_valid = 1'b1;
      if (i == 0 || !toggle_l) i_l = l;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge i_clk);
        acc = o_coeffs_ready;
        if (acc && i == 0) first_acc_cyc = cyc;
        @(posedge i_clk);
        #1;
        if (toggle_l && (acc || i > 0)) i_l = ~i_l;
        guard++;
        if (guard > 1000) begin
          check_eq("beat_timeout", 64'(guard), 64'd0);
          i_coeffs_valid = 1'b0;
          return;
        end
      end
    end
    if (!keep_valid) i_coeffs_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int done_before, input int n_done);
    int guard;
    guard = 0;
    while (done_cnt < done_before + n_done && guard < 3000) begin
      @(posedge i_clk);
      guard++;
    end
    repeat (3) @(posedge i_clk);
    #1;
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - done_before), 64'(n_done));
    check_eq({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_poly(input string tag, input logic [1:0] l, input bit toggle_l,
                          input int exp_words);
    int db;
    db         = done_cnt;
    words_seen = 0;
    push_model(l);
    send_poly(l, 64, toggle_l, 1'b0);
    wait_done(tag, db, 1);
    check_eq({tag, "_words"}, 64'(words_seen), 64'(exp_words));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int db;
    int a_done_cyc;

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_valid", 64'(o_obytes_valid), 64'd0);
    check_eq("rst_obytes", o_obytes, 64'd0);
    check_eq("rst_done", 64'(o_done), 64'd0);
    check_eq("rst_ready", 64'(o_coeffs_ready), 64'd0);
    i_rst = 1'b0;
    #1;
    check_eq("idle_ready", 64'(o_coeffs_ready), 64'd1);

    // d=12 ramp 0..255
    for (int j = 0; j < 256; j++) coef[j] = 12'(j);
    run_poly("d12_ramp", 2'b00, 1'b0, 48);
    check_eq("d12_word0", first_word, 64'h5004003002001000);

    // d=4 all ones with upper bits masked off
    for (int j = 0; j < 256; j++) coef[j] = 12'hFFF;
    run_poly("d4_ones", 2'b11, 1'b0, 16);
    check_eq("d4_word0", first_word, 64'hFFFFFFFFFFFFFFFF);

    // d=10 / d=11 random data under backpressure
    bp_random = 1'b1;
    fill_random();
    run_poly("d10_bp", 2'b10, 1'b0, 40);
    fill_random();
    run_poly("d11_bp", 2'b01, 1'b0, 44);

    // i_l toggling every cycle while packing
    fill_random();
    run_poly("d11_toggle", 2'b01, 1'b1, 44);
    fill_random();
    run_poly("d12_toggle", 2'b00, 1'b1, 48);

    // reset after beat 20 of a d=12 polynomial
    fill_random();
    push_model(2'b00);
    send_poly(2'b00, 20, 1'b0, 1'b0);
    i_rst = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(o_obytes_valid), 64'd0);
    check_eq("midrst_obytes", o_obytes, 64'd0);
    check_eq("midrst_done", 64'(o_done), 64'd0);
    check_eq("midrst_ready", 64'(o_coeffs_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    fill_random();
    run_poly("post_rst", 2'b00, 1'b0, 48);

    // back-to-back polynomials with valid held high
    bp_random = 1'b0;
    db         = done_cnt;
    words_seen = 0;
    fill_random();
    push_model(2'b00);
    send_poly(2'b00, 64, 1'b0, 1'b1);
    fill_random();
    push_model(2'b11);
    send_poly(2'b11, 64, 1'b0, 1'b0);
    a_done_cyc = done_cyc;
    check_eq("b2b_first_accept", 64'(first_acc_cyc), 64'(a_done_cyc + 1));
    wait_done("b2b", db, 2);
    check_eq("b2b_words", 64'(words_seen), 64'd64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
